multicycle_control: RTL and testbench

Main control unit for the multicycle processor. A Moore finite-state machine decodes the latched instruction's opcode and funct fields. Each cycle it drives the datapath select and enable lines, the memory and instruction-register strobes, and the 3-bit ALU operation. It sits directly upstream of the datapath and consumes that datapath's ALU Zero flag to resolve branches.

---
 rtl/multicycle_control.sv | 175 +++++++++++++++++
 tb/tb_multicycle_control.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for the multicycle processor
// Decodes the latched opcode/funct and drives datapath selects, strobes and ALU op each cycle.
module multicycle_control #(
  parameter int ALUSignal  = 3,
  parameter int StateWidth = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [5:0]            Opcode,
  input  logic [5:0]            Funct,
  input  logic                  Zero,
  output logic                  IorD,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  PCEn,
  output logic                  RegDst,
  output logic                  MemToReg,
  output logic                  RegWrite,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            PCSrc,
  output logic [ALUSignal-1:0]  ALUControl,
  output logic                  Illegal,
  output logic [StateWidth-1:0] StateOut
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [ALUSignal-1:0] ALU_ADD = ALUSignal'(3'b010);
  localparam logic [ALUSignal-1:0] ALU_SUB = ALUSignal'(3'b110);
  localparam logic [ALUSignal-1:0] ALU_AND = ALUSignal'(3'b000);
  localparam logic [ALUSignal-1:0] ALU_OR  = ALUSignal'(3'b001);
  localparam logic [ALUSignal-1:0] ALU_SLT = ALUSignal'(3'b111);

  state_t state;
  logic   pc_write;
  logic   branch;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          case (Opcode)
            OP_LW, OP_SW: state <= MEMADR;
            OP_RTYPE:     state <= EXECUTE;
            OP_BEQ:       state <= BRANCH;
            OP_ADDI:      state <= ADDIEXEC;
            OP_J:         state <= JUMP;
            default:      state <= FETCH;
          endcase
        end
        MEMADR:   state <= (Opcode == OP_SW) ? MEMWR : MEMRD;
        MEMRD:    state <= MEMWB;
        EXECUTE:  state <= ALUWB;
        ADDIEXEC: state <= ADDIWB;
        // Every other state (and the unused encodings) completes back to FETCH.
        default:  state <= FETCH;
      endcase
    end
  end

  always_comb begin
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    ALUControl = ALU_ADD;
    Illegal    = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB  = 2'b01;
        IRWrite  = 1'b1;
        pc_write = 1'b1;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        Illegal = !(Opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: IorD = 1'b1;
      MEMWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        case (Funct)
          6'b100000: ALUControl = ALU_ADD;
          6'b100010: ALUControl = ALU_SUB;
          6'b100100: ALUControl = ALU_AND;
          6'b100101: ALUControl = ALU_OR;
          6'b101010: ALUControl = ALU_SLT;
          default:   Illegal    = 1'b1;
        endcase
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        branch     = 1'b1;
      end
      ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: RegWrite = 1'b1;
      JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
    // Reset silences every strobe combinationally so an abandoned instruction issues no write.
    if (RST) begin
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemToReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      PCSrc      = 2'b00;
      ALUControl = '0;
      Illegal    = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
    end
  end

  assign PCEn     = pc_write | (branch & Zero);
  assign StateOut = StateWidth'(state);

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
// Table vectors, async-reset corner case and random instructions against an instruction-level model.
module tb_multicycle_control;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] Opcode = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Zero = 1'b0;
  logic       IorD, MemWrite, IRWrite, PCEn, RegDst, MemToReg, RegWrite, ALUSrcA, Illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] StateOut;

  multicycle_control #(.ALUSignal(3), .StateWidth(4)) dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCEn(PCEn),
    .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl), .Illegal(Illegal),
    .StateOut(StateOut)
  );

  always #5 CLK = ~CLK;

  // {state, iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite, srca, srcb, pcsrc, alu, illegal}
  typedef logic [19:0] out_t;
  out_t act;
  assign act = {StateOut, IorD, MemWrite, IRWrite, PCEn, RegDst, MemToReg, RegWrite, ALUSrcA,
                ALUSrcB, PCSrc, ALUControl, Illegal};

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
  localparam logic [2:0] ADD = 3'b010, SUB = 3'b110;

  int checks = 0;
  int errors = 0;
  out_t expq[$];

  function automatic out_t o(input logic [3:0] st, input logic [7:0] en, input logic [1:0] b,
                             input logic [1:0] p, input logic [2:0] a, input logic ill);
    return {st, en, b, p, a, ill};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // Expected per-cycle outputs of one whole instruction, FETCH first.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
    logic [2:0] alu;
    logic       bad_fn;
    expq.delete();
    expq.push_back(o(4'd0, 8'b0011_0000, 2'b01, 2'b00, ADD, 1'b0));
    expq.push_back(o(4'd1, 8'b0, 2'b11, 2'b00, ADD,
                     !(op inside {R, LW, SW, BEQ, ADDI, J})));
    bad_fn = 1'b0;
    case (fn)
      6'b100000: alu = ADD;
      6'b100010: alu = SUB;
      6'b100100: alu = 3'b000;
      6'b100101: alu = 3'b001;
      6'b101010: alu = 3'b111;
      default: begin alu = ADD; bad_fn = 1'b1; end
    endcase
    case (op)
      LW: begin
        expq.push_back(o(4'd2, 8'b0000_0001, 2'b10, 2'b00, ADD, 1'b0));
        expq.push_back(o(4'd3, 8'b1000_0000, 2'b00, 2'b00, ADD, 1'b0));
        expq.push_back(o(4'd4, 8'b0000_0110, 2'b00, 2'b00, ADD, 1'b0));
      end
      SW: begin
        expq.push_back(o(4'd2, 8'b0000_0001, 2'b10, 2'b00, ADD, 1'b0));
        expq.push_back(o(4'd5, 8'b1100_0000, 2'b00, 2'b00, ADD, 1'b0));
      end
      R: begin
        expq.push_back(o(4'd6, 8'b0000_0001, 2'b00, 2'b00, alu, bad_fn));
        expq.push_back(o(4'd7, 8'b0000_1010, 2'b00, 2'b00, ADD, 1'b0));
      end
      BEQ: expq.push_back(o(4'd8, {3'b000, z, 4'b0001}, 2'b00, 2'b01, SUB, 1'b0));
      ADDI: begin
        expq.push_back(o(4'd9, 8'b0000_0001, 2'b10, 2'b00, ADD, 1'b0));
        expq.push_back(o(4'd10, 8'b0000_0010, 2'b00, 2'b00, ADD, 1'b0));
      end
      J: expq.push_back(o(4'd11, 8'b0001_0000, 2'b00, 2'b10, ADD, 1'b0));
      default: ;
    endcase
  endtask

  // Runs one instruction starting in FETCH (#1 after an edge); returns cycles and Illegal pulses.
  task automatic run(input string nm, input logic [5:0] op, input logic [5:0] fn, input logic z,
                     output int cyc, output int nill);
    build(op, fn, z);
    Opcode = op;
    Funct  = fn;
    Zero   = z;
    cyc    = 0;
    nill   = 0;
    do begin
      @(negedge CLK);
      if (cyc < expq.size()) chk($sformatf("%s cyc%0d", nm, cyc), 32'(act), 32'(expq[cyc]));
      nill += int'(Illegal);
      cyc++;
      @(posedge CLK);
      #1;
    end while (StateOut != 4'd0 && cyc < 10);
  endtask

  typedef struct {
    string      nm;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         lat;
    int         nill;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int   cyc, nill;
    logic [5:0] op, fn;
    logic [5:0] ops[7] = '{R, LW, SW, BEQ, ADDI, J, 6'b111111};
    logic [5:0] fns[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};

    vecs = '{
      '{"lw",       LW,   6'b000000, 1'b0, 5, 0},
      '{"sw",       SW,   6'b000000, 1'b1, 4, 0},
      '{"r_sub",    R,    6'b100010, 1'b0, 4, 0},
      '{"r_slt",    R,    6'b101010, 1'b1, 4, 0},
      '{"r_and",    R,    6'b100100, 1'b0, 4, 0},
      '{"r_or",     R,    6'b100101, 1'b0, 4, 0},
      '{"r_add",    R,    6'b100000, 1'b0, 4, 0},
      '{"r_badfn",  R,    6'b111111, 1'b0, 4, 1},
      '{"addi",     ADDI, 6'b000000, 1'b1, 4, 0},
      '{"beq_z1",   BEQ,  6'b000000, 1'b1, 3, 0},
      '{"beq_z0",   BEQ,  6'b000000, 1'b0, 3, 0},
      '{"j",        J,    6'b000000, 1'b0, 3, 0},
      '{"badop",    6'b111111, 6'b0, 1'b0, 2, 1}
    };

    #2;
    chk("reset_outputs", 32'(act), 32'd0);
    @(posedge CLK); @(posedge CLK); #1;
    chk("reset_held", 32'(act), 32'd0);
    RST = 1'b0;

    foreach (vecs[i]) begin
      run(vecs[i].nm, vecs[i].op, vecs[i].fn, vecs[i].z, cyc, nill);
      chk({vecs[i].nm, " latency"}, 32'(cyc), 32'(vecs[i].lat));
      chk({vecs[i].nm, " illegal_count"}, 32'(nill), 32'(vecs[i].nill));
    end

    // Async reset in MEMRD: outputs drop before any edge, then restart in FETCH.
    Opcode = LW;
    Funct  = 6'd0;
    repeat (3) @(posedge CLK);
    #1;
    chk("pre_reset_state", 32'(StateOut), 32'd3);
    #2 RST = 1'b1;
    #1;
    chk("async_reset_outputs", 32'(act), 32'd0);
    @(negedge CLK);
    chk("async_reset_hold", 32'(act), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    run("post_reset_lw", LW, 6'd0, 1'b0, cyc, nill);
    chk("post_reset_latency", 32'(cyc), 32'd5);

    for (int k = 0; k < 60; k++) begin
      op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      fn = ($urandom_range(0, 5) == 5) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      run($sformatf("rnd%0d op%b fn%b", k, op, fn), op, fn, 1'($urandom), cyc, nill);
      chk($sformatf("rnd%0d latency", k), 32'(cyc), 32'(expq.size()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
